// File: rtl/ser_pkg.sv
// Shared types and helpers for the parameterised serializer.
package ser_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_PAR   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Words narrower than 32 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic word_parity(input logic [31:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/param_serializer.sv
// FIFO-fed parallel-to-serial converter with optional trailing parity bit.
// All outputs are registered; each one is computed from the next-state values.
module param_serializer
  import ser_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsb_first,
  input  logic              empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_fifo,
  output logic              ser_out,
  output logic              piso_start,
  output logic              piso_done,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic              PAR_ODD  = (PARITY_ODD != 0);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                lsb_q, lsb_d;
  logic                par_q, par_d;
  logic                rd_fifo_q, rd_fifo_d;
  logic                ser_out_q, ser_out_d;
  logic                piso_start_q, piso_start_d;
  logic                piso_done_q, piso_done_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    lsb_d     = lsb_q;
    par_d     = par_q;

    case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_READ;
        else        state_d = S_IDLE;
      end
      S_READ: state_d = S_LOAD;
      S_LOAD: begin
        shreg_d   = rd_data;
        lsb_d     = lsb_first;
        par_d     = word_parity(32'(rd_data), PAR_ODD);
        bit_cnt_d = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        shreg_d   = lsb_q ? {1'b0, shreg_q[DATA_W-1:1]} : {shreg_q[DATA_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) state_d = (PARITY_EN != 0) ? S_PAR : S_DONE;
        else                       state_d = S_SHIFT;
      end
      S_PAR:  state_d = S_DONE;
      S_DONE: begin
        if (!empty) state_d = S_READ;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the upcoming state so they line up with it once registered.
    rd_fifo_d    = (state_d == S_READ);
    piso_start_d = (state_d == S_LOAD);
    piso_done_d  = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
    case (state_d)
      S_SHIFT: ser_out_d = lsb_d ? shreg_d[0] : shreg_d[DATA_W-1];
      S_PAR:   ser_out_d = par_d;
      default: ser_out_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      lsb_q        <= 1'b0;
      par_q        <= 1'b0;
      rd_fifo_q    <= 1'b0;
      ser_out_q    <= 1'b0;
      piso_start_q <= 1'b0;
      piso_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      lsb_q        <= lsb_d;
      par_q        <= par_d;
      rd_fifo_q    <= rd_fifo_d;
      ser_out_q    <= ser_out_d;
      piso_start_q <= piso_start_d;
      piso_done_q  <= piso_done_d;
      busy_q       <= busy_d;
    end
  end

  assign rd_fifo    = rd_fifo_q;
  assign ser_out    = ser_out_q;
  assign piso_start = piso_start_q;
  assign piso_done  = piso_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_param_serializer.sv
// Drives three serializer variants (plain, even parity, odd parity) from one FIFO model
// and compares every output every cycle against a frame timeline built from word/timing rules.
module tb_param_serializer;

  localparam int W  = 8;
  localparam int N  = 4096;
  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          rst, lsb_first, empty;
  logic [W-1:0]  rd_data;
  logic [ND-1:0] rd_fifo_v, ser_v, start_v, done_v, busy_v;

  param_serializer #(.DATA_W(W), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_plain (
    .clk(clk), .rst(rst), .lsb_first(lsb_first), .empty(empty), .rd_data(rd_data),
    .rd_fifo(rd_fifo_v[0]), .ser_out(ser_v[0]), .piso_start(start_v[0]),
    .piso_done(done_v[0]), .busy(busy_v[0]));
  param_serializer #(.DATA_W(W), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_even (
    .clk(clk), .rst(rst), .lsb_first(lsb_first), .empty(empty), .rd_data(rd_data),
    .rd_fifo(rd_fifo_v[1]), .ser_out(ser_v[1]), .piso_start(start_v[1]),
    .piso_done(done_v[1]), .busy(busy_v[1]));
  param_serializer #(.DATA_W(W), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_odd (
    .clk(clk), .rst(rst), .lsb_first(lsb_first), .empty(empty), .rd_data(rd_data),
    .rd_fifo(rd_fifo_v[2]), .ser_out(ser_v[2]), .piso_start(start_v[2]),
    .piso_done(done_v[2]), .busy(busy_v[2]));

  always #5 clk = ~clk;

  // Expected outputs per variant per cycle: {rd_fifo, piso_start, piso_done, busy, ser_out}.
  logic [4:0]   exp_o [ND][N];
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] push_q[$];
  int           cyc, nf, pend_r, last_r, lsb_mode, total, bad;
  bit           chk_par, pend_abort;
  string        names[ND] = '{"plain", "even", "odd"};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic clear_from(input int c);
    for (int k = 0; k < ND; k++)
      for (int i = c; i < N; i++) exp_o[k][i] = 5'd0;
  endtask

  // A frame read in cycle r: start at r+1, data bits r+2..r+W+1, optional parity, then done.
  task automatic schedule(input int r);
    for (int k = 0; k < ND; k++) begin
      int d;
      d = r + W + 2 + ((k == 0) ? 0 : 1);
      for (int i = r; i <= d; i++) exp_o[k][i][1] = 1'b1;
      exp_o[k][r][4]   = 1'b1;
      exp_o[k][r+1][3] = 1'b1;
      exp_o[k][d][2]   = 1'b1;
    end
    nf     = r + W + 2;
    pend_r = r;
    last_r = r;
  endtask

  task automatic fill_bits(input int r, input logic [W-1:0] w, input logic lsb);
    for (int k = 0; k < ND; k++) begin
      for (int i = 0; i < W; i++) exp_o[k][r+2+i][0] = lsb ? w[i] : w[W-1-i];
      if (k > 0) exp_o[k][r+2+W][0] = (^w) ^ (k == 2);
    end
  endtask

  task automatic step(input bit r_in);
    logic [W-1:0] w;
    @(negedge clk);
    cyc++;
    if (cyc >= N - 4 * W) begin
      $display("FAIL cycle_budget cyc=%0d got=over want=under", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    for (int k = 0; k < ND; k++)
      if (k == 0 || chk_par)
        check_eq($sformatf("outs_%s", names[k]),
                 32'({rd_fifo_v[k], start_v[k], done_v[k], busy_v[k], ser_v[k]}),
                 32'(exp_o[k][cyc]));
    if (r_in && !rst) begin
      pend_abort = (pend_r == cyc);
      if (!pend_abort) pend_r = -1;
      clear_from(cyc + 1);
    end
    if (!r_in && rst) nf = cyc;
    rst = r_in;
    case (lsb_mode)
      0:       lsb_first = 1'b0;
      1:       lsb_first = 1'b1;
      default: lsb_first = 1'($urandom_range(0, 1));
    endcase
    if (pend_r >= 0 && cyc == pend_r + 1) begin
      w = fifo_q.pop_front();
      if (pend_abort) rd_data = W'($urandom);
      else begin
        rd_data = w;
        fill_bits(pend_r, w, lsb_first);
      end
      pend_r     = -1;
      pend_abort = 1'b0;
    end else begin
      rd_data = W'($urandom);
    end
    while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
    empty = (fifo_q.size() == 0);
    check_eq("rd_fifo_while_empty", 32'(rd_fifo_v[0] & empty), 32'd0);
    if (!rst && cyc >= nf && !empty && pend_r < 0) schedule(cyc + 1);
  endtask

  initial begin
    rst = 1'b1; empty = 1'b1; lsb_first = 1'b0; rd_data = '0;
    cyc = 0; nf = 0; pend_r = -1; last_r = 0; total = 0; bad = 0;
    chk_par = 1'b1; pend_abort = 1'b0; lsb_mode = 2;
    clear_from(0);
    repeat (3) step(1'b1);

    // Long empty stretch: nothing may move.
    repeat (100) step(1'b0);

    lsb_mode = 0; push_q.push_back(8'hA5); repeat (20) step(1'b0);
    lsb_mode = 1; push_q.push_back(8'h01); repeat (20) step(1'b0);
    lsb_mode = 2; push_q.push_back(8'h07); repeat (20) step(1'b0);
    lsb_mode = 0; push_q.push_back(8'h07); repeat (20) step(1'b0);

    lsb_mode = 2;
    for (int i = 0; i < 10; i++) begin
      push_q.push_back(W'($urandom));
      repeat ($urandom_range(14, 20)) step(1'b0);
    end

    // Abort in the fourth shift cycle, then a fresh frame after release.
    push_q.push_back(8'h5A);
    step(1'b0);
    while (cyc < last_r + 4) step(1'b0);
    step(1'b1);
    step(1'b1);
    push_q.push_back(8'h96);
    repeat (20) step(1'b0);

    // Back-to-back traffic on the plain variant only.
    chk_par = 1'b0;
    push_q.push_back(8'h3C);
    push_q.push_back(8'hC3);
    repeat (40) step(1'b0);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) push_q.push_back(W'($urandom));
      step(1'b0);
    end
    for (int i = 0; i < 1200 && (fifo_q.size() > 0 || push_q.size() > 0 || pend_r >= 0); i++)
      step(1'b0);
    repeat (20) step(1'b0);

    step(1'b1);
    chk_par = 1'b1;
    step(1'b1);
    repeat (5) step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_serializer.md
PARAM_SERIALIZER -- requirements
Module: param_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the word width in bits (legal range 2..32).
REQ-002 SHALL have parameter PARITY_EN, default 0, meaning a parity bit is appended after the data bits when set to 1.
REQ-003 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port lsb_first  input  1  bit order: 1 = LSB first, 0 = MSB first; sampled once per frame.
REQ-007 SHALL have port empty  input  1  FIFO empty flag.
REQ-008 SHALL have port rd_data  input  DATA_W  FIFO read data, valid the cycle after rd_fifo.
REQ-009 SHALL have port rd_fifo  output  1  FIFO pop strobe, one-cycle pulse.
REQ-010 SHALL have port ser_out  output  1  serial data; 0 when no bit is being driven.
REQ-011 SHALL have port piso_start  output  1  one-cycle frame-start pulse.
REQ-012 SHALL have port piso_done  output  1  one-cycle frame-end pulse.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, READ, LOAD, SHIFT, PAR and DONE.
REQ-015 IDLE SHALL go to READ when empty=0, else stay in IDLE.
REQ-016 READ SHALL assert rd_fifo for exactly one cycle and always go to LOAD.
REQ-017 LOAD SHALL capture rd_data into the shift register, latch lsb_first, compute parity (XOR of the word, inverted if PARITY_ODD), assert piso_start, clear bit_cnt, and go to SHIFT.
REQ-018 SHIFT SHALL drive ser_out = shreg[DATA_W-1] (MSB mode) or shreg[0] (LSB mode), shift one position per cycle, and increment bit_cnt.
REQ-019 SHIFT SHALL last exactly DATA_W cycles and then go to PAR if PARITY_EN=1, else to DONE.
REQ-020 PAR SHALL drive ser_out = parity bit for one cycle and then go to DONE.
REQ-021 DONE SHALL assert piso_done for one cycle and go to READ if empty=0, else to IDLE (back-to-back frames).
REQ-022 Latency: with empty falling in cycle T while in IDLE, rd_fifo SHALL be high in T+1, piso_start in T+2, first bit in T+3, last data bit in T+2+DATA_W.
REQ-023 Frame period SHALL be DATA_W+3 cycles (DATA_W+4 with parity) under continuous back-to-back operation.
REQ-024 rd_fifo SHALL never assert while empty=1 or outside READ.
REQ-025 Changes to empty, lsb_first and rd_data outside IDLE/DONE, READ and LOAD respectively SHALL have no effect on the current frame.
REQ-026 ser_out SHALL be 0 in IDLE, READ, LOAD and DONE.
REQ-027 bit_cnt width SHALL be $clog2(DATA_W+1); it SHALL NOT wrap within a frame.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL enter IDLE, and rd_fifo, ser_out, piso_start, piso_done, busy, shreg and bit_cnt SHALL all be 0.
REQ-029 Reset mid-frame SHALL abort the frame with no piso_done; an already-popped word is discarded.
REQ-030 rst SHALL take priority over every FSM transition.

Structure
REQ-031 Package ser_pkg SHALL hold the state enum typedef and the default DATA_W constant.
REQ-032 The block SHALL be one flat module with no sub-modules; parity SHALL be a package function.

Verification
REQ-033 DATA_W=8, MSB mode, FIFO holds 0xA5 -> ser_out 1,0,1,0,0,1,0,1 over 8 cycles; piso_start one cycle before, piso_done one cycle after.
REQ-034 LSB mode, word 0x01 -> ser_out 1,0,0,0,0,0,0,0.
REQ-035 PARITY_EN=1, even parity, word 0x07 -> ninth bit 1; with PARITY_ODD=1 -> ninth bit 0.
REQ-036 Two words 0x3C and 0xC3 queued -> exactly two rd_fifo pulses, spaced 11 cycles apart, with no IDLE cycle between frames.
REQ-037 rst asserted in the 4th SHIFT cycle -> next cycle all outputs 0, no piso_done, and a fresh frame starts from READ once rst falls and empty=0.
REQ-038 empty held at 1 for 100 cycles -> rd_fifo, busy and ser_out stay 0 throughout.
